minmax_window_ctrl: RTL
=======================

Name: minmax_window_ctrl

Overview:
- Sequencing controller around a signed running max/min tracker.
- Accepts a sample stream over a valid/ready handshake and groups it into fixed-length windows of WIN_LEN samples.
- Emits each window's signed max and min through an output valid/ready handshake.
- Sits between the sample source and downstream consumers; supports single-shot and continuous windowing with synchronous abort.

Parameters:
- DATA_W, 32, sample and result width (signed two's complement).
- WIN_LEN, 8, samples per window; legal range 2..255.
- CNT_W, 8, width of the window-completion counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a window; sampled only in IDLE.
- continuous  input  1  1 = after result handoff, open the next window automatically; 0 = return to IDLE.
- abort  input  1  synchronous cancel of the current window.
- in_valid  input  1  in_data valid.
- in_data  input  DATA_W  signed sample.
- in_ready  output  1  controller accepts a sample this cycle.
- out_valid  output  1  out_max/out_min hold a completed window result.
- out_ready  input  1  consumer takes the result.
- out_max  output  DATA_W  signed maximum of the last window.
- out_min  output  DATA_W  signed minimum of the last window.
- busy  output  1  state != IDLE.
- win_cnt  output  CNT_W  count of completed windows handed off.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, sample counter=0.
  - out_max=0, out_min=0, out_valid=0, in_ready=0, busy=0, win_cnt=0.
  - Applies immediately, including mid-window and mid-handoff; any partial window is discarded.
- States: IDLE, ACCUM, DONE.
  - in_ready=1 only in ACCUM.
  - out_valid=1 only in DONE.
- IDLE:
  - start=1 -> ACCUM, sample counter=0.
  - Otherwise stay. in_valid is ignored.
- ACCUM: a sample is accepted on any cycle with in_valid=1 (in_ready is 1).
  - First accepted sample (counter=0): out_max and out_min both load in_data.
  - Later samples:
    - out_max <= in_data if in_data > out_max (signed compare).
    - out_min <= in_data if in_data < out_min (signed compare).
    - Equal values leave the register unchanged.
  - Counter increments per accepted sample. in_valid=0 cycles are bubbles and do not count.
  - Accepting sample number WIN_LEN -> DONE. out_valid rises the cycle after the last sample is accepted (1-cycle latency).
- DONE:
  - out_max/out_min stay stable while out_valid=1 and out_ready=0. No samples are consumed.
  - On out_valid and out_ready both 1:
    - win_cnt increments, wrapping at 2^CNT_W.
    - Next state is ACCUM with counter=0 if continuous=1, else IDLE.
    - out_max/out_min retain their values until the next first sample loads.
- abort=1:
  - In ACCUM or DONE, abort wins over every other event in the same cycle (sample accept, handoff, start).
  - Next state IDLE, counter=0, out_valid=0.
  - win_cnt is not incremented; out_max/out_min are cleared to 0.
  - In IDLE, abort has no effect and blocks start that cycle.
- start=1 outside IDLE is ignored.
- continuous is sampled only at the handoff cycle.
- No arithmetic widening: compares only, so no overflow cases. Most-negative and most-positive DATA_W values must be handled correctly.

Test Plan (WIN_LEN=4, default widths):
- Reset check: reset low mid-ACCUM, asynchronous to clock -> all outputs 0 within the same time step, state IDLE; after release, start required before in_ready=1.
- Single window: start, then samples 2, 3, -8, 56 back-to-back, continuous=0 -> out_valid one cycle after 56 is accepted; out_max=56, out_min=-8; after out_ready, win_cnt=1, busy=0.
- Backpressure and bubbles:
  - Samples 90, gap, -8, gap, 12, -90 give out_max=90, out_min=-90.
  - Then hold out_ready=0 for 5 cycles with in_valid=1 and in_data=77: in_ready=0 throughout, results unchanged, 77 never counted.
- Continuous mode: continuous=1, windows {-12,12,25,18} then {0,3,0,-12} -> (25,-12) then (3,-12); win_cnt=2; no IDLE cycle between windows.
- Abort:
  - Abort after samples 125, 125 -> IDLE, out_valid=0, win_cnt unchanged.
  - New start with {125,125,-125,200} -> (200,-125).
  - Abort asserted on the same cycle as out_ready in DONE -> IDLE, win_cnt not incremented.
- Extremes: window {-2^31, 2^31-1, 0, -1} -> out_max=2^31-1, out_min=-2^31.

Source files
------------

// File: rtl/minmax_window_ctrl.sv
// Windowed signed max/min tracker: groups a valid/ready sample stream into
// WIN_LEN-sample windows and hands each window's extremes downstream.
module minmax_window_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WIN_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic              i_abort,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_max,
  output logic [DATA_W-1:0] o_out_min,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_win_cnt
);

  // Sample counter only needs to reach WIN_LEN-1; the last accept moves to DONE.
  localparam int unsigned SCNT_W = (WIN_LEN < 2) ? 1 : $clog2(WIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SCNT_W-1:0]   r_cnt;
  logic [SCNT_W-1:0]   w_cnt_nxt;
  logic [DATA_W-1:0]   r_max;
  logic [DATA_W-1:0]   w_max_nxt;
  logic [DATA_W-1:0]   r_min;
  logic [DATA_W-1:0]   w_min_nxt;
  logic [CNT_W-1:0]    r_win_cnt;
  logic [CNT_W-1:0]    w_win_nxt;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                w_cnt_last;

  assign w_cnt_last = (r_cnt == SCNT_W'(WIN_LEN - 1));

  // Next-state and datapath update; abort overrides every other event in ACCUM/DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_max_nxt   = r_max;
    w_min_nxt   = r_min;
    w_win_nxt   = r_win_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = S_ACCUM;
          w_cnt_nxt   = '0;
        end
      end
      S_ACCUM: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_max_nxt   = '0;
          w_min_nxt   = '0;
        end else if (i_in_valid) begin
          if (r_cnt == '0) begin
            w_max_nxt = i_in_data;
            w_min_nxt = i_in_data;
          end else begin
            if ($signed(i_in_data) > $signed(r_max)) w_max_nxt = i_in_data;
            if ($signed(i_in_data) < $signed(r_min)) w_min_nxt = i_in_data;
          end
          if (w_cnt_last) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + SCNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_max_nxt   = '0;
          w_min_nxt   = '0;
        end else if (i_out_ready) begin
          w_win_nxt   = r_win_cnt + CNT_W'(1);
          w_cnt_nxt   = '0;
          w_state_nxt = i_continuous ? S_ACCUM : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, datapath and registered status flags decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_max       <= '0;
      r_min       <= '0;
      r_win_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_max       <= w_max_nxt;
      r_min       <= w_min_nxt;
      r_win_cnt   <= w_win_nxt;
      r_in_ready  <= (w_state_nxt == S_ACCUM);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_max   = r_max;
  assign o_out_min   = r_min;
  assign o_busy      = r_busy;
  assign o_win_cnt   = r_win_cnt;

endmodule
